alu_cmd_queue: RTL and testbench
================================

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command queue depth (power of two, 2..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per raw key input.
REQ-003 clock  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 push_key  input  1  raw asynchronous pushbutton, active-low; a press enqueues one command.
REQ-006 step_key  input  1  raw asynchronous pushbutton, active-low; a press issues one command to the ALU.
REQ-007 flush  input  1  synchronous, active-high; empties the queue.
REQ-008 cmd_a  input  4  operand A captured on push.
REQ-009 cmd_mode  input  3  ALU function select captured on push.
REQ-010 alu_a  output  4  operand A driven to the ALU; registered.
REQ-011 alu_mode  output  3  function select driven to the ALU; registered.
REQ-012 alu_en  output  1  one-cycle strobe; downstream result register loads ALU output when high.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 full, empty  output  1 each  occupancy == DEPTH, occupancy == 0.
REQ-015 overflow  output  1  sticky flag: a push was dropped because the queue was full.

Function
REQ-016 Each key SHALL pass through SYNC_STAGES flops, then a falling-edge detector producing a one-cycle internal pulse (push_p, step_p) per press.
REQ-017 With key low first sampled at edge E0 and SYNC_STAGES=2, the pulse SHALL be high in the cycle following edge E0+1 and take effect at edge E0+2.
REQ-018 A held key SHALL produce exactly one pulse; release SHALL produce none.
REQ-019 push_p with queue not full SHALL write {cmd_mode, cmd_a} at the write pointer and increment it modulo DEPTH.
REQ-020 push_p with queue full and no step_p SHALL drop the command, leave state unchanged, and set overflow.
REQ-021 step_p with queue not empty SHALL load alu_a/alu_mode from the head entry, assert alu_en for the next cycle only, and advance the read pointer modulo DEPTH.
REQ-022 step_p with queue empty SHALL be ignored; alu_en stays low; no bypass of a same-cycle push.
REQ-023 Simultaneous push_p and step_p with queue full SHALL both succeed, count unchanged, overflow unchanged.
REQ-024 Simultaneous push_p and step_p with 0 < count < DEPTH SHALL both succeed, count unchanged.
REQ-025 flush SHALL, at the next edge, zero both pointers, count and overflow, suppress that cycle's push/step, and leave alu_a/alu_mode unchanged; alu_en low.
REQ-026 alu_a/alu_mode SHALL hold the last issued values between strobes.
REQ-027 Issue latency: step_p cycle N -> alu_en high in cycle N+1 with head values on alu_a/alu_mode; one command issued per press, maximum.
REQ-028 count SHALL update combinationally from registered pointers and be consistent with full/empty every cycle.

Reset
REQ-029 reset low at an edge SHALL clear pointers, storage-valid state, count, overflow, alu_en, alu_a, alu_mode (all to 0) and set synchronizer flops to 1 (keys released).
REQ-030 Reset SHALL override flush, push_p and step_p; a key held low through reset release SHALL NOT produce a pulse.
REQ-031 Reset mid-queue SHALL discard all stored commands.

Structure
REQ-032 Shared package SHALL hold CMD_W=7, the command field layout (mode [6:4], A [3:0]) and the eight ALU mode encodings 3'b000..3'b111.
REQ-033 One sub-module key_edge (synchronizer plus falling-edge detector, parameter SYNC_STAGES) SHALL be instantiated twice.
REQ-034 Storage SHALL be a flop array of DEPTH x CMD_W; no inferred RAM.

Verification
REQ-035 Push cmds (mode=3'b001,A=4'h3),(3'b111,4'h5) then two steps -> alu_en pulses twice; alu_mode/alu_a = 001/3 then 111/5; empty=1 at end.
REQ-036 Five pushes with DEPTH=4 -> count=4, full=1, overflow=1; four steps return first four commands in order.
REQ-037 Queue full, push and step pulses in same cycle -> count stays 4, overflow stays 0, issued head correct, new tail stored.
REQ-038 Step on empty queue -> alu_en stays 0, alu_a/alu_mode unchanged.
REQ-039 Push key held low 20 cycles -> exactly one enqueue, pulse at edge E0+2.
REQ-040 Three pushes, then flush -> count=0, empty=1, overflow=0, alu_a/alu_mode unchanged; reset with push_key held low -> no enqueue after release of reset.

Source files
------------

// File: rtl/alu_cmd_queue_pkg.sv
// Shared types and constants for the ALU command queue.
// Command word layout, field positions and ALU mode encodings.
package alu_cmd_queue_pkg;

  localparam int CMD_W   = 7;
  localparam int MODE_HI = 6;
  localparam int MODE_LO = 4;
  localparam int A_HI    = 3;
  localparam int A_LO    = 0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_mode_e;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [2:0] mode,
    input logic [3:0] a
  );
    return {mode, a};
  endfunction

endpackage

// File: rtl/alu_cmd_queue_key_edge.sv
// key_edge: synchronizer chain plus falling-edge detector for a raw
// active-low key. Ports: clock, reset (sync, low), key_n in, pulse out.
module key_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Tracks which chain stages hold genuine samples since reset, so a
  // key held low through reset release is not mistaken for a press.
  logic [SYNC_STAGES-1:0] real_q, real_d;
  logic                   high_q, high_d;
  logic                   last;
  logic                   last_real;

  assign last      = sync_q[SYNC_STAGES-1];
  assign last_real = real_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    real_d    = real_q;
    sync_d[0] = key_n;
    real_d[0] = 1'b1;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
      real_d[i] = real_q[i-1];
    end
    high_d = last_real & last;
  end

  assign pulse = high_q & last_real & ~last;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '1;
      real_q <= '0;
      high_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      real_q <= real_d;
      high_q <= high_d;
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Debounced-key command queue feeding an ALU. Ports: clock, reset,
// push_key/step_key/flush, cmd_a/cmd_mode in; alu_*, count/full/empty/overflow out.
module alu_cmd_queue
  import alu_cmd_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_key,
  input  logic                     step_key,
  input  logic                     flush,
  input  logic [3:0]               cmd_a,
  input  logic [2:0]               cmd_mode,
  output logic [3:0]               alu_a,
  output logic [2:0]               alu_mode,
  output logic                     alu_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic push_p, step_p;

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_push (
    .clock (clock),
    .reset (reset),
    .key_n (push_key),
    .pulse (push_p)
  );

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step (
    .clock (clock),
    .reset (reset),
    .key_n (step_key),
    .pulse (step_p)
  );

  // Pointers carry one extra wrap bit so full and empty differ.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [2:0]       alu_mode_q, alu_mode_d;
  logic             alu_en_q, alu_en_d;
  logic [CMD_W-1:0] head;
  logic             do_push, do_step;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    ovf_d      = ovf_q;
    alu_a_d    = alu_a_q;
    alu_mode_d = alu_mode_q;
    // A push into a full queue still fits when the head leaves together.
    do_push    = push_p & (~full | step_p);
    do_step    = step_p & ~empty;
    alu_en_d   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = pack_cmd(cmd_mode, cmd_a);
        wr_ptr_d = wr_ptr_q + ONE;
      end
      if (push_p & full & ~step_p)
        ovf_d = 1'b1;
      if (do_step) begin
        alu_a_d    = head[A_HI:A_LO];
        alu_mode_d = head[MODE_HI:MODE_LO];
        alu_en_d   = 1'b1;
        rd_ptr_d   = rd_ptr_q + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_mode_q <= '0;
      alu_en_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      alu_a_q    <= alu_a_d;
      alu_mode_q <= alu_mode_d;
      alu_en_q   <= alu_en_d;
      mem_q      <= mem_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_mode = alu_mode_q;
  assign alu_en   = alu_en_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue (DEPTH=4, SYNC_STAGES=2).
// Hand-computed expectations checked with immediate assertions.
module tb_alu_cmd_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       push_key = 1'b1;
  logic       step_key = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] cmd_a = '0;
  logic [2:0] cmd_mode = '0;
  logic [3:0] alu_a;
  logic [2:0] alu_mode;
  logic       alu_en;
  logic [2:0] count;
  logic       full, empty, overflow;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;

  alu_cmd_queue #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .push_key (push_key),
    .step_key (step_key),
    .flush    (flush),
    .cmd_a    (cmd_a),
    .cmd_mode (cmd_mode),
    .alu_a    (alu_a),
    .alu_mode (alu_mode),
    .alu_en   (alu_en),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      if (alu_en) en_cnt++;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic p, input logic s,
                       input logic [2:0] m, input logic [3:0] a);
    cmd_mode = m;
    cmd_a    = a;
    en_cnt   = 0;
    push_key = ~p;
    step_key = ~s;
    tick(3);
    push_key = 1'b1;
    step_key = 1'b1;
    tick(4);
  endtask

  task automatic do_flush();
    en_cnt = 0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_count", 8'(count), 8'd0);
    check("rst_empty", 8'(empty), 8'd1);
    check("rst_full", 8'(full), 8'd0);
    check("rst_ovf", 8'(overflow), 8'd0);
    check("rst_en", 8'(alu_en), 8'd0);
    check("rst_a", 8'(alu_a), 8'd0);
    check("rst_mode", 8'(alu_mode), 8'd0);
    reset = 1'b1;
    tick(4);

    // two pushes, two steps
    press(1, 0, 3'b001, 4'h3);
    press(1, 0, 3'b111, 4'h5);
    check("two_push_count", 8'(count), 8'd2);
    press(0, 1, 3'b000, 4'h0);
    check("step1_en", 8'(en_cnt), 8'd1);
    check("step1_mode", 8'(alu_mode), 8'd1);
    check("step1_a", 8'(alu_a), 8'h3);
    press(0, 1, 3'b000, 4'h0);
    check("step2_en", 8'(en_cnt), 8'd1);
    check("step2_mode", 8'(alu_mode), 8'd7);
    check("step2_a", 8'(alu_a), 8'h5);
    check("step2_empty", 8'(empty), 8'd1);

    // step on empty queue
    press(0, 1, 3'b000, 4'h0);
    check("empty_step_en", 8'(en_cnt), 8'd0);
    check("empty_step_a", 8'(alu_a), 8'h5);
    check("empty_step_mode", 8'(alu_mode), 8'd7);

    // five pushes into depth four
    for (int i = 0; i < 5; i++) begin
      press(1, 0, 3'(i), 4'(4'hA + i));
      if (i == 3) begin
        check("fill_full", 8'(full), 8'd1);
        check("fill_ovf", 8'(overflow), 8'd0);
      end
    end
    check("ovf_count", 8'(count), 8'd4);
    check("ovf_full", 8'(full), 8'd1);
    check("ovf_set", 8'(overflow), 8'd1);
    for (int i = 0; i < 4; i++) begin
      press(0, 1, 3'b000, 4'h0);
      check("drain_en", 8'(en_cnt), 8'd1);
      check("drain_mode", 8'(alu_mode), 8'(i));
      check("drain_a", 8'(alu_a), 8'(4'hA + i));
    end
    check("drain_empty", 8'(empty), 8'd1);
    check("ovf_sticky", 8'(overflow), 8'd1);
    do_flush();
    check("flush_ovf_clr", 8'(overflow), 8'd0);

    // full queue, push and step in the same cycle
    press(1, 0, 3'd2, 4'h1);
    press(1, 0, 3'd3, 4'h2);
    press(1, 0, 3'd4, 4'h3);
    press(1, 0, 3'd5, 4'h4);
    press(1, 1, 3'd6, 4'h9);
    check("both_en", 8'(en_cnt), 8'd1);
    check("both_mode", 8'(alu_mode), 8'd2);
    check("both_a", 8'(alu_a), 8'h1);
    check("both_count", 8'(count), 8'd4);
    check("both_ovf", 8'(overflow), 8'd0);
    press(0, 1, 3'd0, 4'h0);
    check("both_d1", 8'({alu_mode, alu_a}), 8'h32);
    press(0, 1, 3'd0, 4'h0);
    check("both_d2", 8'({alu_mode, alu_a}), 8'h43);
    press(0, 1, 3'd0, 4'h0);
    check("both_d3", 8'({alu_mode, alu_a}), 8'h54);
    press(0, 1, 3'd0, 4'h0);
    check("both_tail", 8'({alu_mode, alu_a}), 8'h69);
    check("both_empty", 8'(empty), 8'd1);

    // held push key: one enqueue at E0+2
    cmd_mode = 3'd1;
    cmd_a    = 4'h6;
    push_key = 1'b0;
    tick(2);
    check("hold_e1", 8'(count), 8'd0);
    tick(1);
    check("hold_e2", 8'(count), 8'd1);
    tick(17);
    check("hold_20", 8'(count), 8'd1);
    push_key = 1'b1;
    tick(4);
    check("hold_release", 8'(count), 8'd1);
    press(0, 1, 3'd0, 4'h0);
    check("hold_issue", 8'({alu_mode, alu_a}), 8'h16);

    // flush after three pushes
    press(1, 0, 3'd2, 4'h1);
    press(1, 0, 3'd3, 4'h2);
    press(1, 0, 3'd4, 4'h3);
    check("pre_flush", 8'(count), 8'd3);
    do_flush();
    check("flush_count", 8'(count), 8'd0);
    check("flush_empty", 8'(empty), 8'd1);
    check("flush_ovf", 8'(overflow), 8'd0);
    check("flush_en", 8'(en_cnt), 8'd0);
    check("flush_alu", 8'({alu_mode, alu_a}), 8'h16);

    // reset mid-queue with push key held through release
    press(1, 0, 3'd5, 4'h5);
    check("pre_rst", 8'(count), 8'd1);
    cmd_mode = 3'd7;
    cmd_a    = 4'hF;
    reset    = 1'b0;
    push_key = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(10);
    check("rst_held_count", 8'(count), 8'd0);
    check("rst_held_alu", 8'({alu_mode, alu_a}), 8'h00);
    push_key = 1'b1;
    tick(4);
    check("rst_release", 8'(count), 8'd0);
    press(1, 0, 3'd7, 4'hF);
    check("post_rst_push", 8'(count), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
